// File: rtl/cpu_alarm_rtc_pkg.sv
// cpu_alarm_rtc_pkg: register map, FSM encoding and reset constants shared by
// the alarm clock top and its timekeeper.
package cpu_alarm_rtc_pkg;
   localparam logic [2:0] ADDR_STATUS = 3'd0;
   localparam logic [2:0] ADDR_CTRL   = 3'd1;
   localparam logic [2:0] ADDR_MINSEC = 3'd2;
   localparam logic [2:0] ADDR_HOUR   = 3'd3;
   localparam logic [2:0] ADDR_ALARM  = 3'd4;
   localparam logic [2:0] ADDR_SNOOZE = 3'd5;
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RINGING  = 2'd1,
      ST_SNOOZING = 2'd2
   } state_e;
   localparam logic [4:0]  RST_ALARM_HOUR = 5'd7;
   localparam logic [5:0]  RST_ALARM_MIN  = 6'd0;
   localparam logic [5:0]  SEC_MAX        = 6'd59;
   localparam logic [5:0]  MIN_MAX        = 6'd59;
   localparam logic [4:0]  HOUR_MAX       = 5'd23;
   localparam logic [15:0] SEC_PER_MIN    = 16'd60;
endpackage

// File: rtl/cpu_alarm_rtc_timekeeper.sv
// cpu_alarm_rtc_timekeeper: hh:mm:ss counter with CPU load ports; a load in
// the same cycle as a step wins and suppresses the step.
module cpu_alarm_rtc_timekeeper
   import cpu_alarm_rtc_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       inc_i,
   input  logic       ld_ms_i,
   input  logic       ld_hour_i,
   input  logic [5:0] ld_min_i,
   input  logic [5:0] ld_sec_i,
   input  logic [4:0] ld_hour_val_i,
   output logic [5:0] sec_o,
   output logic [5:0] min_o,
   output logic [4:0] hour_o,
   output logic [5:0] sec_d_o,
   output logic [5:0] min_d_o,
   output logic [4:0] hour_d_o,
   output logic       stepped_o,
   output logic       carry_o
);
   logic [5:0] sec_q, sec_d, min_q, min_d;
   logic [4:0] hour_q, hour_d;
   logic       step, c_sec, c_min;

   // >= rather than == so out-of-range loaded values self-correct on the next carry
   always_comb begin
      step    = inc_i & ~ld_ms_i & ~ld_hour_i;
      c_sec   = step & (sec_q >= SEC_MAX);
      c_min   = c_sec & (min_q >= MIN_MAX);
      carry_o = c_min & (hour_q >= HOUR_MAX);
      sec_d   = ld_ms_i ? ld_sec_i : step ? (c_sec ? '0 : sec_q + 6'd1) : sec_q;
      min_d   = ld_ms_i ? ld_min_i : c_sec ? (c_min ? '0 : min_q + 6'd1) : min_q;
      hour_d  = ld_hour_i ? ld_hour_val_i : c_min ? (carry_o ? '0 : hour_q + 5'd1) : hour_q;
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sec_q  <= '0;
         min_q  <= '0;
         hour_q <= '0;
      end else begin
         sec_q  <= sec_d;
         min_q  <= min_d;
         hour_q <= hour_d;
      end

   assign sec_o     = sec_q;
   assign min_o     = min_q;
   assign hour_o    = hour_q;
   assign sec_d_o   = sec_d;
   assign min_d_o   = min_d;
   assign hour_d_o  = hour_d;
   assign stepped_o = step;
endmodule

// File: rtl/cpu_alarm_rtc.sv
// cpu_alarm_rtc: Avalon-mapped real-time clock with alarm, snooze and
// auto-dismiss ring timeout.
module cpu_alarm_rtc
   import cpu_alarm_rtc_pkg::*;
#(
   parameter int RING_TIMEOUT   = 60,
   parameter int SNOOZE_DEFAULT = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick_in,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq,
   output logic        buzzer
);
   localparam logic [15:0] RING_LAST = 16'(RING_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] ring_cnt_q, ring_cnt_d, snz_cnt_q, snz_cnt_d, readdata_q, readdata_d;
   logic        tick_q, flag_q, flag_d, irq_en_q, alarm_en_q, run_q;
   logic [4:0]  alarm_hour_q;
   logic [5:0]  alarm_min_q;
   logic [3:0]  snooze_min_q;
   logic [5:0]  sec, min, sec_d, min_d;
   logic [4:0]  hour, hour_d;
   logic        sec_event, wr, wr_status, wr_ctrl, ld_ms, ld_hour, snooze_stb, dismiss;
   logic        stepped, alarm_hit, ring_set, day_carry;
   logic        unused_bits;

   assign sec_event   = tick_in & ~tick_q;
   assign wr          = chipselect & ~write_n;
   assign wr_status   = wr & (address == ADDR_STATUS);
   assign wr_ctrl     = wr & (address == ADDR_CTRL);
   assign ld_ms       = wr & (address == ADDR_MINSEC);
   assign ld_hour     = wr & (address == ADDR_HOUR);
   assign snooze_stb  = wr_ctrl & writedata[3];
   assign dismiss     = (wr_status & writedata[2]) | (wr_ctrl & ~writedata[1]);
   assign unused_bits = ^{writedata[15:14], writedata[7:6], day_carry};

   cpu_alarm_rtc_timekeeper u_tk (
      .clk           (clk),
      .reset_n       (reset_n),
      .inc_i         (sec_event & run_q),
      .ld_ms_i       (ld_ms),
      .ld_hour_i     (ld_hour),
      .ld_min_i      (writedata[13:8]),
      .ld_sec_i      (writedata[5:0]),
      .ld_hour_val_i (writedata[4:0]),
      .sec_o         (sec),
      .min_o         (min),
      .hour_o        (hour),
      .sec_d_o       (sec_d),
      .min_d_o       (min_d),
      .hour_d_o      (hour_d),
      .stepped_o     (stepped),
      .carry_o       (day_carry)
   );

   // match against the time this tick produces, so the alarm fires on the hh:mm:00 edge itself
   assign alarm_hit = stepped & alarm_en_q & (hour_d == alarm_hour_q)
                    & (min_d == alarm_min_q) & (sec_d == 6'd0);

   always_comb begin
      state_d    = state_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      ring_set   = 1'b0;
      case (state_q)
         ST_IDLE:
            if (alarm_hit) begin
               state_d    = ST_RINGING;
               ring_cnt_d = '0;
               ring_set   = 1'b1;
            end
         ST_RINGING:
            if (dismiss) state_d = ST_IDLE;
            else if (snooze_stb) begin
               state_d   = ST_SNOOZING;
               snz_cnt_d = 16'(snooze_min_q) * SEC_PER_MIN;
            end else if (sec_event) begin
               if (ring_cnt_q == RING_LAST) state_d = ST_IDLE;
               else ring_cnt_d = ring_cnt_q + 16'd1;
            end
         ST_SNOOZING:
            if (dismiss) state_d = ST_IDLE;
            else if (sec_event) begin
               if (snz_cnt_q <= 16'd1) begin
                  state_d    = ST_RINGING;
                  ring_cnt_d = '0;
                  ring_set   = 1'b1;
               end else snz_cnt_d = snz_cnt_q - 16'd1;
            end
         default: state_d = ST_IDLE;
      endcase
      flag_d = ring_set | (flag_q & ~wr_status);
   end

   always_comb
      readdata_d = (address == ADDR_STATUS) ? {13'd0, state_q == ST_RINGING, run_q, flag_q} :
                   (address == ADDR_CTRL)   ? {13'd0, run_q, alarm_en_q, irq_en_q} :
                   (address == ADDR_MINSEC) ? {2'd0, min, 2'd0, sec} :
                   (address == ADDR_HOUR)   ? {11'd0, hour} :
                   (address == ADDR_ALARM)  ? {3'd0, alarm_hour_q, 2'd0, alarm_min_q} :
                   (address == ADDR_SNOOZE) ? {12'd0, snooze_min_q} : '0;

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         ring_cnt_q   <= '0;
         snz_cnt_q    <= '0;
         tick_q       <= 1'b0;
         flag_q       <= 1'b0;
         irq_en_q     <= 1'b0;
         alarm_en_q   <= 1'b0;
         run_q        <= 1'b0;
         alarm_hour_q <= RST_ALARM_HOUR;
         alarm_min_q  <= RST_ALARM_MIN;
         snooze_min_q <= 4'(SNOOZE_DEFAULT);
         readdata_q   <= '0;
      end else begin
         state_q    <= state_d;
         ring_cnt_q <= ring_cnt_d;
         snz_cnt_q  <= snz_cnt_d;
         tick_q     <= tick_in;
         flag_q     <= flag_d;
         readdata_q <= readdata_d;
         if (wr_ctrl) begin
            irq_en_q   <= writedata[0];
            alarm_en_q <= writedata[1];
            run_q      <= writedata[2];
         end
         if (wr & (address == ADDR_ALARM)) begin
            alarm_hour_q <= writedata[12:8];
            alarm_min_q  <= writedata[5:0];
         end
         if (wr & (address == ADDR_SNOOZE)) snooze_min_q <= writedata[3:0];
      end

   assign readdata = readdata_q;
   assign irq      = flag_q & irq_en_q;
   assign buzzer   = state_q == ST_RINGING;
endmodule

// File: tb/tb_cpu_alarm_rtc.sv
// tb_cpu_alarm_rtc: directed checks of time keeping, alarm, snooze, timeout,
// dismiss, write/tick collision and mid-ring reset.
module tb_cpu_alarm_rtc;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        tick_in = 1'b0;
   logic [2:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = '0;
   logic [15:0] readdata;
   logic        irq, buzzer;
   logic [15:0] rv;
   int          checks = 0;
   int          errors = 0;

   cpu_alarm_rtc dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tick_in    (tick_in),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .irq        (irq),
      .buzzer     (buzzer)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [2:0] a, output logic [15:0] d);
      @(posedge clk); #1;
      address = a; chipselect = 1'b1; write_n = 1'b1;
      @(posedge clk); #1;
      d = readdata;
      chipselect = 1'b0;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1 tick_in = 1'b1;
         @(posedge clk); #1 tick_in = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic bits(input string tag, input logic b_irq, input logic b_buz, input logic e_irq, input logic e_buz);
      check({tag, "_irq"}, {15'd0, b_irq}, {15'd0, e_irq});
      check({tag, "_buzzer"}, {15'd0, b_buz}, {15'd0, e_buz});
   endtask

   task automatic ring_at_seven();
      wr(3'd3, 16'd6);
      wr(3'd2, 16'h3B3B);
      wr(3'd1, 16'h0007);
      tick_n(1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      rd(3'd0, rv); check("rst_status", rv, 16'h0000);
      rd(3'd1, rv); check("rst_ctrl", rv, 16'h0000);
      rd(3'd2, rv); check("rst_minsec", rv, 16'h0000);
      rd(3'd3, rv); check("rst_hour", rv, 16'h0000);
      rd(3'd4, rv); check("rst_alarm", rv, 16'h0700);
      rd(3'd5, rv); check("rst_snooze", rv, 16'h0005);
      rd(3'd6, rv); check("unmapped", rv, 16'h0000);
      bits("rst", irq, buzzer, 1'b0, 1'b0);

      // rollover
      wr(3'd2, 16'h3B3B);
      wr(3'd3, 16'd23);
      wr(3'd1, 16'h0006);
      tick_n(1);
      rd(3'd2, rv); check("roll_minsec", rv, 16'h0000);
      rd(3'd3, rv); check("roll_hour", rv, 16'h0000);
      rd(3'd0, rv); check("roll_status", rv, 16'h0002);
      tick_n(1);
      rd(3'd2, rv); check("inc_minsec", rv, 16'h0001);
      wr(3'd1, 16'h0000);
      tick_n(1);
      rd(3'd2, rv); check("stopped_minsec", rv, 16'h0001);

      // out-of-range seconds corrected at next carry
      wr(3'd1, 16'h0004);
      wr(3'd2, 16'h3B3E);
      rd(3'd2, rv); check("oor_stored", rv, 16'h3B3E);
      tick_n(1);
      rd(3'd2, rv); check("oor_minsec", rv, 16'h0000);
      rd(3'd3, rv); check("oor_hour", rv, 16'h0001);

      // alarm
      ring_at_seven();
      bits("alarm", irq, buzzer, 1'b1, 1'b1);
      rd(3'd0, rv); check("alarm_status", rv, 16'h0007);
      wr(3'd0, 16'h0000);
      bits("ack", irq, buzzer, 1'b0, 1'b1);
      rd(3'd0, rv); check("ack_status", rv, 16'h0006);

      // snooze for one minute
      wr(3'd5, 16'h0001);
      wr(3'd1, 16'h000F);
      bits("snooze", irq, buzzer, 1'b0, 1'b0);
      rd(3'd1, rv); check("ctrl_strobe_not_stored", rv, 16'h0007);
      tick_n(59);
      bits("snooze59", irq, buzzer, 1'b0, 1'b0);
      tick_n(1);
      bits("snooze60", irq, buzzer, 1'b1, 1'b1);
      rd(3'd0, rv); check("snooze_status", rv, 16'h0007);

      // ring timeout
      tick_n(59);
      check("ring59", {15'd0, buzzer}, 16'h0001);
      tick_n(1);
      check("ring60", {15'd0, buzzer}, 16'h0000);
      rd(3'd0, rv); check("timeout_status", rv, 16'h0003);

      // dismiss while snoozing
      wr(3'd0, 16'h0000);
      ring_at_seven();
      check("ring2", {15'd0, buzzer}, 16'h0001);
      wr(3'd1, 16'h000F);
      wr(3'd0, 16'h0004);
      rd(3'd0, rv); check("dismiss_status", rv, 16'h0002);
      tick_n(61);
      bits("dismissed", irq, buzzer, 1'b0, 1'b0);

      // clearing alarm_en beats a same-write snooze strobe
      wr(3'd5, 16'h0000);
      ring_at_seven();
      check("ring3", {15'd0, buzzer}, 16'h0001);
      wr(3'd1, 16'h000D);
      tick_n(1);
      check("dis_beats_snooze", {15'd0, buzzer}, 16'h0000);
      rd(3'd1, rv); check("dis_ctrl", rv, 16'h0005);

      // write beats same-cycle tick
      wr(3'd2, 16'h0102);
      @(posedge clk); #1;
      tick_in = 1'b1; address = 3'd2; writedata = 16'h0A05; chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      tick_in = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      rd(3'd2, rv); check("collide_minsec", rv, 16'h0A05);

      // reset mid-ring
      wr(3'd0, 16'h0000);
      ring_at_seven();
      bits("prerst", irq, buzzer, 1'b1, 1'b1);
      @(posedge clk); #1 reset_n = 1'b0;
      #1 bits("inrst", irq, buzzer, 1'b0, 1'b0);
      check("inrst_readdata", readdata, 16'h0000);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      rd(3'd2, rv); check("postrst_minsec", rv, 16'h0000);
      rd(3'd3, rv); check("postrst_hour", rv, 16'h0000);
      rd(3'd0, rv); check("postrst_status", rv, 16'h0000);
      tick_n(2);
      bits("postrst", irq, buzzer, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/cpu_alarm_rtc.md
CPU_ALARM_RTC -- requirements
Module: cpu_alarm_rtc

Interface
REQ-001 SHALL have port clk, input, 1 bit, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-003 SHALL have port tick_in, input, 1 bit, 1 Hz timeout pulse/level from the upstream interval timer; each rising edge is one second.
REQ-004 SHALL have Avalon slave ports address (input, 3 bits), chipselect (input, 1), write_n (input, 1), writedata (input, 16), readdata (output, 16, registered).
REQ-005 SHALL have port irq, output, 1 bit, alarm interrupt to the CPU.
REQ-006 SHALL have port buzzer, output, 1 bit, high while the alarm is ringing.
REQ-007 SHALL have parameter RING_TIMEOUT, default 60, seconds of ringing before auto-dismiss.
REQ-008 SHALL have parameter SNOOZE_DEFAULT, default 5, reset value of the snooze-minutes register.

Function
REQ-009 SHALL detect a second as tick_in high while its one-cycle-delayed copy is low (sec_event, one cycle wide).
REQ-010 SHALL map registers: 0 status {ringing[2], running[1], alarm_flag[0]}; 1 control {snooze[3], run[2], alarm_en[1], irq_en[0]}; 2 {min[13:8], sec[5:0]}; 3 hour[4:0]; 4 alarm {hour[12:8], min[5:0]}; 5 snooze_min[3:0].
REQ-011 SHALL return register contents on readdata one clock after address is presented (read latency 1, no wait states); unmapped addresses read 0.
REQ-012 SHALL, on sec_event with run=1, increment sec; sec>=59 wraps to 0 and carries min; min>=59 wraps and carries hour; hour>=23 wraps to 0 (23:59:59 -> 00:00:00).
REQ-013 SHALL give a write to address 2 or 3 priority over a same-cycle sec_event: written value loads, no increment that cycle.
REQ-014 SHALL store out-of-range written time values unchanged; the >= comparisons in REQ-012 correct them on the next carry.
REQ-015 SHALL treat control bit 3 as a write-strobe only (not stored; reads 0).
REQ-016 SHALL implement FSM states IDLE, RINGING, SNOOZING; buzzer=1 only in RINGING.
REQ-017 SHALL go IDLE->RINGING on sec_event when alarm_en=1, run=1 and the post-increment time equals alarm hh:mm with sec=0; alarm_flag set same cycle.
REQ-018 SHALL go RINGING->SNOOZING on snooze strobe, loading a seconds countdown of snooze_min*60; snooze_min=0 returns to RINGING on the next sec_event.
REQ-019 SHALL go SNOOZING->RINGING when the countdown reaches 0 on a sec_event, setting alarm_flag again.
REQ-020 SHALL go RINGING->IDLE after RING_TIMEOUT sec_events in RINGING (counter restarts at each entry).
REQ-021 SHALL go to IDLE from RINGING or SNOOZING on a status write with writedata[2]=1 (dismiss) or a control write clearing alarm_en; dismiss beats same-cycle snooze.
REQ-022 SHALL ignore snooze strobes in IDLE and SNOOZING.
REQ-023 SHALL clear alarm_flag on any status write; a same-cycle set event wins over clear.
REQ-024 SHALL drive irq = alarm_flag AND irq_en, combinationally from registers.
REQ-025 SHALL report running = run AND (state != IDLE or counting enabled), i.e. running = run.

Reset
REQ-026 SHALL, on reset_n low, force: time 00:00:00, alarm 07:00, snooze_min=SNOOZE_DEFAULT, control=0, alarm_flag=0, state IDLE, countdowns 0, edge-detect register 0, readdata=0, irq=0, buzzer=0.
REQ-027 SHALL abandon any ring/snooze in progress on reset mid-operation, without a spurious irq after release.

Structure
REQ-028 SHALL place register address constants, FSM state encodings and reset constants in shared package cpu_alarm_rtc_pkg.
REQ-029 SHALL implement the sec/min/hour counter (REQ-012..014) as sub-module cpu_alarm_rtc_timekeeper with a load port and a carry-out.

Verification
REQ-030 SHALL cover rollover: load 23:59:59, run=1, one tick_in edge -> time 00:00:00, no alarm.
REQ-031 SHALL cover alarm: alarm 07:00, time 06:59:59, alarm_en=irq_en=run=1, one tick -> buzzer=1, irq=1, status reads 0x7; status write 0x0 -> irq=0, buzzer stays 1.
REQ-032 SHALL cover snooze: ringing, snooze_min=1, control write bit3 -> buzzer=0; 59 ticks -> buzzer 0; 60th tick -> buzzer=1, alarm_flag=1.
REQ-033 SHALL cover timeout and dismiss: 60 ticks in RINGING -> IDLE; separately status write 0x4 while SNOOZING -> IDLE, buzzer stays 0.
REQ-034 SHALL cover collisions: write address 2 value 0x0A05 same cycle as sec_event -> reads 0x0A05; reset_n pulsed while ringing -> all outputs 0, time 00:00:00.
